// File: rtl/mbe_r8_pp_generator.sv
// mbe_r8_pp_generator
//   Radix-8 modified-Booth partial-product generator for a 24x24 multiplier.
//   Stage 1 registers the sign/zero-extended operands and the hard multiple 3A;
//   stage 2 Booth-selects and negates each of the 9 rows into the output regs.
//   Latency 2 cycles; one op per cycle; valid/ready on both sides, holds when stalled.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_a, in_b, in_tc, in_tag operand pair + sideband
//   out_valid/out_ready output handshake; pp_out[k] (weight 2^(3k)), out_tag
module mbe_r8_pp_generator #(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_a,
  input  logic [23:0]       in_b,
  input  logic              in_tc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0][31:0]  pp_out,
  output logic [TAG_W-1:0]  out_tag
);

  // Stage 1 registers
  logic              s1_v;
  logic [25:0]       s1_a;
  logic [26:0]       s1_a3;
  logic [26:0]       s1_b;
  logic              s1_tc;
  logic [TAG_W-1:0]  s1_tag;

  // Handshake / pipeline control
  logic in_fire;
  logic s2_load;

  assign in_ready = !s1_v || !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_v && (!out_valid || out_ready);

  // Stage 1 datapath: operand extension and 3A
  logic [25:0] a_ext;
  logic [26:0] b_ext;
  logic [26:0] a3;

  always_comb begin
    a_ext = in_tc ? {{2{in_a[23]}}, in_a} : {2'b00, in_a};
    b_ext = in_tc ? {{3{in_b[23]}}, in_b} : {3'b000, in_b};
    a3    = {a_ext[25], a_ext} + {a_ext, 1'b0};
  end

  // Booth digit select for one row. bits = {b[3k+2], b[3k+1], b[3k], b[3k-1]}.
  // The digit is formed mod 16 so the 4-bit result reads as a signed value in [-4,4].
  function automatic logic [31:0] booth_row(
    input logic [3:0]  bits,
    input logic [31:0] m1,
    input logic [31:0] m2,
    input logic [31:0] m3,
    input logic [31:0] m4
  );
    logic [3:0]  d;
    logic [31:0] mag;
    logic        neg;
    d = {2'b00, bits[2], 1'b0} + {3'b000, bits[1]} + {3'b000, bits[0]}
        - {1'b0, bits[3], 2'b00};
    mag = '0;
    neg = 1'b0;
    case (d)
      4'd1:    mag = m1;
      4'd2:    mag = m2;
      4'd3:    mag = m3;
      4'd4:    mag = m4;
      4'hF:    begin mag = m1; neg = 1'b1; end
      4'hE:    begin mag = m2; neg = 1'b1; end
      4'hD:    begin mag = m3; neg = 1'b1; end
      4'hC:    begin mag = m4; neg = 1'b1; end
      default: mag = '0;
    endcase
    // Full two's-complement negation kept inside the row (no separate correction bit).
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  // Stage 2 datapath
  logic [31:0]      m1, m2, m3, m4;
  logic [27:0]      bx;
  logic [8:0][31:0] pp_next;

  always_comb begin
    m1 = {{6{s1_a[25]}}, s1_a};
    m2 = {m1[30:0], 1'b0};
    m4 = {m1[29:0], 2'b00};
    m3 = {{5{s1_a3[26]}}, s1_a3};
    bx = {s1_b, 1'b0};          // append the implicit b[-1] = 0
    pp_next = '0;
    for (int k = 0; k < 9; k++) begin
      pp_next[k] = booth_row(bx[3*k+3 -: 4], m1, m2, m3, m4);
    end
    // In signed mode the top digit sees only copies of the sign bit, so it is zero.
    if (s1_tc) begin
      pp_next[8] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_a3     <= '0;
      s1_b      <= '0;
      s1_tc     <= 1'b0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      pp_out    <= '0;
      out_tag   <= '0;
    end else begin
      if (in_fire) begin
        s1_a   <= a_ext;
        s1_a3  <= a3;
        s1_b   <= b_ext;
        s1_tc  <= in_tc;
        s1_tag <= in_tag;
      end
      if (in_fire) begin
        s1_v <= 1'b1;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      if (s2_load) begin
        pp_out    <= pp_next;
        out_tag   <= s1_tag;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mbe_r8_pp_generator.sv
// tb_mbe_r8_pp_generator
//   Directed vectors with hand-computed rows/sums, stall/ordering and reset-flush
//   scenarios, then a randomized run against a behavioural Booth model.
module tb_mbe_r8_pp_generator;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [23:0]      in_a;
  logic [23:0]      in_b;
  logic             in_tc;
  logic [3:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [8:0][31:0] pp_out;
  logic [3:0]       out_tag;

  mbe_r8_pp_generator #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tc     (in_tc),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_out    (pp_out),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sum_k sext(row_k) << 3k, mod 2^48
  function automatic logic [47:0] wsum(input logic [8:0][31:0] r);
    logic [47:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) begin
      s = s + ({{16{r[k][31]}}, r[k]} << (3 * k));
    end
    return s;
  endfunction

  function automatic longint ext24(input logic [23:0] v, input logic tc);
    return tc ? longint'($signed(v)) : longint'(v);
  endfunction

  // Behavioural reference: row k = d_k * A as an integer, truncated to 32 bits.
  function automatic logic [8:0][31:0] model_rows(input logic [23:0] a, input logic [23:0] b,
                                                  input logic tc);
    logic [8:0][31:0] r;
    longint av, bv, p;
    longint b2, b1, b0, bm;
    av = ext24(a, tc);
    bv = ext24(b, tc);
    for (int k = 0; k < 9; k++) begin
      b2 = (bv >>> (3 * k + 2)) & 1;
      b1 = (bv >>> (3 * k + 1)) & 1;
      b0 = (bv >>> (3 * k)) & 1;
      bm = (k == 0) ? 0 : ((bv >>> (3 * k - 1)) & 1);
      p  = (-4 * b2 + 2 * b1 + b0 + bm) * av;
      r[k] = p[31:0];
    end
    return r;
  endfunction

  function automatic logic [47:0] model_prod(input logic [23:0] a, input logic [23:0] b,
                                             input logic tc);
    longint p;
    p = ext24(a, tc) * ext24(b, tc);
    return p[47:0];
  endfunction

  // Scoreboard for the random phase
  typedef struct {
    logic [3:0]       tag;
    logic [8:0][31:0] rows;
    logic [47:0]      prod;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("rnd_tag", 64'(out_tag), 64'(e.tag));
          for (int k = 0; k < 9; k++) begin
            chk($sformatf("rnd_row%0d", k), 64'(pp_out[k]), 64'(e.rows[k]));
          end
          chk("rnd_sum", 64'(wsum(pp_out)), 64'(e.prod));
        end
      end
      if (in_valid && in_ready) begin
        e.tag  = in_tag;
        e.rows = model_rows(in_a, in_b, in_tc);
        e.prod = model_prod(in_a, in_b, in_tc);
        q.push_back(e);
      end
    end
  end

  // Single op with no backpressure; checks 2-cycle latency and hand-computed rows.
  task automatic run_dir(input string nm, input logic [23:0] a, input logic [23:0] b,
                         input logic tc, input logic [3:0] tag,
                         input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e8,
                         input logic [47:0] esum);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = a; in_b = b; in_tc = tc; in_tag = tag;
    tick();
    in_valid = 1'b0;
    chk({nm, "_vld_c1"}, 64'(out_valid), 64'(0));
    tick();
    chk({nm, "_vld_c2"}, 64'(out_valid), 64'(1));
    chk({nm, "_row0"}, 64'(pp_out[0]), 64'(e0));
    chk({nm, "_row1"}, 64'(pp_out[1]), 64'(e1));
    chk({nm, "_row8"}, 64'(pp_out[8]), 64'(e8));
    chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
    chk({nm, "_sum"}, 64'(wsum(pp_out)), 64'(esum));
    tick();
    chk({nm, "_drained"}, 64'(out_valid), 64'(0));
  endtask

  logic [8:0][31:0] held;
  int sent, cyc;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tc = 1'b0; in_tag = '0;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_pp", 64'(wsum(pp_out)), 64'(0));
    chk("rst_pp_any", 64'(|pp_out), 64'(0));
    chk("rst_tag", 64'(out_tag), 64'(0));
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed vectors
    run_dir("t1", 24'd1, 24'd1, 1'b0, 4'd1, 32'd1, 32'd0, 32'd0, 48'd1);
    run_dir("t2", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'd2,
            32'hFF000001, 32'd0, 32'h00FFFFFF, 48'hFFFFFE000001);
    run_dir("t3", 24'd3, 24'h000004, 1'b0, 4'd3, 32'hFFFFFFF4, 32'd3, 32'd0, 48'd12);
    run_dir("t4", 24'hFFFFFF, 24'h000002, 1'b1, 4'd4,
            32'hFFFFFFFE, 32'd0, 32'd0, 48'hFFFFFFFFFFFE);

    // Stall: out_ready low, three ops offered, only two fit
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 24'd100; in_b = 24'd7; in_tc = 1'b0; in_tag = 4'd1;
    #1 chk("st_rdy1", 64'(in_ready), 64'(1));
    tick();
    in_a = 24'h800000; in_b = 24'h123456; in_tc = 1'b1; in_tag = 4'd2;
    #1 chk("st_rdy2", 64'(in_ready), 64'(1));
    tick();
    in_a = 24'hABCDEF; in_b = 24'hFEDCBA; in_tc = 1'b0; in_tag = 4'd3;
    #1 chk("st_rdy3_blocked", 64'(in_ready), 64'(0));
    chk("st_vld", 64'(out_valid), 64'(1));
    chk("st_tag_head", 64'(out_tag), 64'(1));
    held = pp_out;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_rows", 64'(wsum(pp_out ^ held)), 64'(0));
      chk("st_hold_any", 64'(|(pp_out ^ held)), 64'(0));
      chk("st_hold_tag", 64'(out_tag), 64'(1));
      chk("st_hold_rdy", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    #1 chk("st_rel_rdy", 64'(in_ready), 64'(1));
    chk("st_out1_sum", 64'(wsum(pp_out)), 64'(model_prod(24'd100, 24'd7, 1'b0)));
    tick();
    in_valid = 1'b0;
    chk("st_out2_vld", 64'(out_valid), 64'(1));
    chk("st_out2_tag", 64'(out_tag), 64'(2));
    chk("st_out2_sum", 64'(wsum(pp_out)), 64'(model_prod(24'h800000, 24'h123456, 1'b1)));
    tick();
    chk("st_out3_vld", 64'(out_valid), 64'(1));
    chk("st_out3_tag", 64'(out_tag), 64'(3));
    chk("st_out3_sum", 64'(wsum(pp_out)), 64'(model_prod(24'hABCDEF, 24'hFEDCBA, 1'b0)));
    tick();
    chk("st_empty", 64'(out_valid), 64'(0));

    // Reset with two ops in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 24'd55; in_b = 24'd66; in_tc = 1'b0; in_tag = 4'd5;
    tick();
    in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("rf_inflight", 64'(out_valid), 64'(1));
    rst = 1'b1;
    tick();
    chk("rf_vld", 64'(out_valid), 64'(0));
    chk("rf_pp", 64'(|pp_out), 64'(0));
    chk("rf_tag", 64'(out_tag), 64'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rf_no_stale", 64'(out_valid), 64'(0));
    end

    // Random traffic against the model
    mon_en = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF :
                  ($urandom_range(0, 7) == 0) ? 24'h800000 : 24'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF :
                  ($urandom_range(0, 7) == 0) ? 24'h800000 : 24'($urandom);
      in_tc     = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    chk("rnd_sent", 64'(sent), 64'(1000));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      tick();
    end
    tick();
    chk("rnd_drain", 64'(q.size()), 64'(0));
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
